// File: rtl/uart_rx_pkg.sv
// Shared constants, frame-length helper and latched frame-format type for the UART RX frame timer.
package uart_rx_pkg;

  localparam int MIN_PRESC = 4;
  localparam int MIN_DBITS = 5;
  localparam int MAX_DBITS = 9;
  localparam int FLEN_W    = 5;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       par_en;
    logic       stop2;
  } frame_cfg_t;

  // Wide enough for any 4-bit data_bits, so out-of-range configs are still measurable.
  function automatic logic [FLEN_W-1:0] frame_len(input logic [3:0] data_bits,
                                                  input logic       par_en,
                                                  input logic       stop2);
    return FLEN_W'(2) + FLEN_W'(data_bits) + FLEN_W'(par_en) + FLEN_W'(stop2);
  endfunction

endpackage

// File: rtl/uart_rx_sample_decode.sv
// Decodes the edge counter into sample strobes; UART_RX_TRIPLE_SAMPLE_EN selects
// three strobes around mid-bit (majority vote) instead of a single mid-bit strobe.
module uart_rx_sample_decode #(
  parameter int PRESC_W = 6
) (
  input  logic [PRESC_W-1:0] edge_cnt_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic               enable_i,
  output logic               sample_stb_o,
  output logic [1:0]         sample_idx_o
);

  logic [PRESC_W-1:0] mid;

  // Floor of half a bit: odd prescale samples slightly early.
  assign mid = prescale_i >> 1;

  always_comb begin
    sample_stb_o = 1'b0;
    sample_idx_o = 2'd0;
`ifdef UART_RX_TRIPLE_SAMPLE_EN
    if (enable_i) begin
      if (edge_cnt_i == mid - PRESC_W'(1)) begin
        sample_stb_o = 1'b1;
        sample_idx_o = 2'd0;
      end else if (edge_cnt_i == mid) begin
        sample_stb_o = 1'b1;
        sample_idx_o = 2'd1;
      end else if (edge_cnt_i == mid + PRESC_W'(1)) begin
        sample_stb_o = 1'b1;
        sample_idx_o = 2'd2;
      end
    end
`else
    if (enable_i && (edge_cnt_i == mid)) begin
      sample_stb_o = 1'b1;
      sample_idx_o = 2'd1;
    end
`endif
  end

endmodule

// File: rtl/uart_rx_frame_timer.sv
// UART RX oversampling frame timer: edge/bit counters, run-time frame length and config latch.
// Optional build macro UART_RX_TRIPLE_SAMPLE_EN (handled in uart_rx_sample_decode).
module uart_rx_frame_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W   = 6,
  parameter int BCNT_W    = 4,
  parameter int MAX_FRAME = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic [3:0]         data_bits_i,
  input  logic               par_en_i,
  input  logic               stop2_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [BCNT_W-1:0]  bit_cnt_o,
  output logic               sample_stb_o,
  output logic [1:0]         sample_idx_o,
  output logic               bit_tick_o,
  output logic               frame_done_o,
  output logic               cfg_err_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  frame_cfg_t         cfg_q, cfg_d;
  logic               cfg_vld_q, cfg_vld_d;
  logic               cfg_err_q, cfg_err_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BCNT_W-1:0]  bit_q, bit_d;
  logic [FLEN_W-1:0]  flen_d, flen_q;
  logic [BCNT_W-1:0]  last_bit;
  logic               run, edge_last, bit_last;

  // Config follows the inputs whenever the timer is idle and is frozen while counting.
  always_comb begin
    presc_d   = presc_q;
    cfg_d     = cfg_q;
    cfg_vld_d = cfg_vld_q;
    if (!enable_i) begin
      presc_d   = prescale_i;
      cfg_d     = '{data_bits: data_bits_i, par_en: par_en_i, stop2: stop2_i};
      cfg_vld_d = 1'b1;
    end
  end

  assign flen_d    = frame_len(cfg_d.data_bits, cfg_d.par_en, cfg_d.stop2);
  assign cfg_err_d = (presc_d < PRESC_W'(MIN_PRESC))
                   | (cfg_d.data_bits < 4'(MIN_DBITS))
                   | (cfg_d.data_bits > 4'(MAX_DBITS))
                   | (flen_d > FLEN_W'(MAX_FRAME));

  assign flen_q   = frame_len(cfg_q.data_bits, cfg_q.par_en, cfg_q.stop2);
  assign last_bit = BCNT_W'(flen_q - FLEN_W'(1));

  // cfg_vld_q keeps the all-zero reset config from ever counting before a real latch.
  assign run       = enable_i & cfg_vld_q & ~cfg_err_q;
  assign edge_last = (edge_q == presc_q - PRESC_W'(1));
  assign bit_last  = (bit_q == last_bit);

  always_comb begin
    edge_d = '0;
    bit_d  = '0;
    if (run) begin
      if (edge_last) begin
        edge_d = '0;
        bit_d  = bit_last ? '0 : bit_q + BCNT_W'(1);
      end else begin
        edge_d = edge_q + PRESC_W'(1);
        bit_d  = bit_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      cfg_q     <= '0;
      cfg_vld_q <= 1'b0;
      cfg_err_q <= 1'b0;
      edge_q    <= '0;
      bit_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      cfg_q     <= cfg_d;
      cfg_vld_q <= cfg_vld_d;
      cfg_err_q <= cfg_err_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
    end
  end

  uart_rx_sample_decode #(.PRESC_W(PRESC_W)) u_sample_decode (
    .edge_cnt_i   (edge_q),
    .prescale_i   (presc_q),
    .enable_i     (run),
    .sample_stb_o (sample_stb_o),
    .sample_idx_o (sample_idx_o)
  );

  assign edge_cnt_o   = edge_q;
  assign bit_cnt_o    = bit_q;
  assign bit_tick_o   = run & edge_last;
  assign frame_done_o = run & edge_last & bit_last;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Directed self-checking bench for uart_rx_frame_timer (either UART_RX_TRIPLE_SAMPLE_EN build).
module tb_uart_rx_frame_timer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [5:0] prescale_i;
  logic [3:0] data_bits_i;
  logic       par_en_i;
  logic       stop2_i;
  logic [5:0] edge_cnt_o;
  logic [3:0] bit_cnt_o;
  logic       sample_stb_o;
  logic [1:0] sample_idx_o;
  logic       bit_tick_o;
  logic       frame_done_o;
  logic       cfg_err_o;

  int vec = 0;
  int err = 0;

`ifdef UART_RX_TRIPLE_SAMPLE_EN
  localparam bit TRIPLE = 1'b1;
`else
  localparam bit TRIPLE = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  uart_rx_frame_timer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .prescale_i   (prescale_i),
    .data_bits_i  (data_bits_i),
    .par_en_i     (par_en_i),
    .stop2_i      (stop2_i),
    .edge_cnt_o   (edge_cnt_o),
    .bit_cnt_o    (bit_cnt_o),
    .sample_stb_o (sample_stb_o),
    .sample_idx_o (sample_idx_o),
    .bit_tick_o   (bit_tick_o),
    .frame_done_o (frame_done_o),
    .cfg_err_o    (cfg_err_o)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int p, input int d, input bit par, input bit s2);
    enable_i    = 1'b0;
    prescale_i  = 6'(p);
    data_bits_i = 4'(d);
    par_en_i    = par;
    stop2_i     = s2;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b1;
    prescale_i = 6'd8; data_bits_i = 4'd8; par_en_i = 1'b0; stop2_i = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    vec++; if (edge_cnt_o !== 6'd0) begin err++; $display("FAIL reset_edge got %0d exp 0", edge_cnt_o); end
    vec++; if (bit_cnt_o !== 4'd0) begin err++; $display("FAIL reset_bit got %0d exp 0", bit_cnt_o); end
    vec++; if ({sample_stb_o, bit_tick_o, frame_done_o} !== 3'b000)
      begin err++; $display("FAIL reset_strobes got %b exp 000", {sample_stb_o, bit_tick_o, frame_done_o}); end
    vec++; if (cfg_err_o !== 1'b0) begin err++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err_o); end
    next_cycle();
    rst_i = 1'b0;
    next_cycle();
    // Still enabled but nothing latched yet: the timer must not run on the zero config.
    @(negedge clk_i);
    vec++; if ({edge_cnt_o, bit_tick_o, sample_stb_o} !== 8'd0)
      begin err++; $display("FAIL reset_idle got %0d/%b/%b exp 0/0/0", edge_cnt_o, bit_tick_o, sample_stb_o); end
    next_cycle();
  endtask

  task automatic test_basic_frame();
    logic [5:0] ee;
    logic [3:0] eb;
    logic       et, ed;
    set_cfg(8, 8, 1'b0, 1'b0);
    enable_i = 1'b1;
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk_i);
      ee = 6'((n - 1) % 8);
      eb = 4'(((n - 1) / 8) % 10);
      et = ((n % 8) == 0);
      ed = ((n % 80) == 0);
      vec++; if (edge_cnt_o !== ee) begin err++; $display("FAIL basic_edge c%0d got %0d exp %0d", n, edge_cnt_o, ee); end
      vec++; if (bit_cnt_o !== eb) begin err++; $display("FAIL basic_bit c%0d got %0d exp %0d", n, bit_cnt_o, eb); end
      vec++; if (bit_tick_o !== et) begin err++; $display("FAIL basic_tick c%0d got %b exp %b", n, bit_tick_o, et); end
      vec++; if (frame_done_o !== ed) begin err++; $display("FAIL basic_done c%0d got %b exp %b", n, frame_done_o, ed); end
      next_cycle();
    end
    enable_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_max_frame();
    set_cfg(16, 9, 1'b1, 1'b1);
    @(negedge clk_i);
    vec++; if (cfg_err_o !== 1'b1) begin err++; $display("FAIL flen13_cfg_err got %b exp 1", cfg_err_o); end
    next_cycle();
    set_cfg(16, 8, 1'b1, 1'b1);
    @(negedge clk_i);
    vec++; if (cfg_err_o !== 1'b0) begin err++; $display("FAIL flen12_cfg_err got %b exp 0", cfg_err_o); end
    next_cycle();
    enable_i = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk_i);
      vec++; if (frame_done_o !== (n == 192)) begin err++; $display("FAIL max_done c%0d got %b exp %b", n, frame_done_o, (n == 192)); end
      if (n == 192) begin
        vec++; if (bit_cnt_o !== 4'd11) begin err++; $display("FAIL max_lastbit got %0d exp 11", bit_cnt_o); end
        vec++; if (edge_cnt_o !== 6'd15) begin err++; $display("FAIL max_lastedge got %0d exp 15", edge_cnt_o); end
      end
      if (n == 193) begin
        vec++; if (bit_cnt_o !== 4'd0) begin err++; $display("FAIL max_wrap got %0d exp 0", bit_cnt_o); end
      end
      next_cycle();
    end
    enable_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_sample_points();
    int  presc_tab [2];
    int  m, e;
    bit  es;
    logic [1:0] ei;
    presc_tab[0] = 8;
    presc_tab[1] = 7;
    for (int k = 0; k < 2; k++) begin
      set_cfg(presc_tab[k], 8, 1'b0, 1'b0);
      enable_i = 1'b1;
      m = presc_tab[k] / 2;
      for (int n = 1; n <= presc_tab[k]; n++) begin
        @(negedge clk_i);
        e  = n - 1;
        es = TRIPLE ? (e >= m - 1 && e <= m + 1) : (e == m);
        ei = TRIPLE ? 2'(e - m + 1) : 2'd1;
        vec++; if (sample_stb_o !== es)
          begin err++; $display("FAIL stb_p%0d_e%0d got %b exp %b", presc_tab[k], e, sample_stb_o, es); end
        if (es) begin
          vec++; if (sample_idx_o !== ei)
            begin err++; $display("FAIL idx_p%0d_e%0d got %0d exp %0d", presc_tab[k], e, sample_idx_o, ei); end
        end
        next_cycle();
      end
      enable_i = 1'b0;
      next_cycle();
    end
  endtask

  task automatic test_cfg_err();
    set_cfg(3, 8, 1'b0, 1'b0);
    @(negedge clk_i);
    vec++; if (cfg_err_o !== 1'b1) begin err++; $display("FAIL presc3_cfg_err got %b exp 1", cfg_err_o); end
    next_cycle();
    enable_i = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk_i);
      vec++; if ({edge_cnt_o, bit_cnt_o, sample_stb_o, bit_tick_o, frame_done_o} !== 13'd0)
        begin err++; $display("FAIL err_hold c%0d got e%0d b%0d s%b t%b d%b exp all 0", n, edge_cnt_o, bit_cnt_o,
                              sample_stb_o, bit_tick_o, frame_done_o); end
      next_cycle();
    end
    set_cfg(8, 8, 1'b0, 1'b0);
    @(negedge clk_i);
    vec++; if (cfg_err_o !== 1'b0) begin err++; $display("FAIL fixed_cfg_err got %b exp 0", cfg_err_o); end
    next_cycle();
    set_cfg(8, 4, 1'b0, 1'b0);
    @(negedge clk_i);
    vec++; if (cfg_err_o !== 1'b1) begin err++; $display("FAIL dbits4_cfg_err got %b exp 1", cfg_err_o); end
    next_cycle();
    set_cfg(8, 10, 1'b0, 1'b0);
    @(negedge clk_i);
    vec++; if (cfg_err_o !== 1'b1) begin err++; $display("FAIL dbits10_cfg_err got %b exp 1", cfg_err_o); end
    next_cycle();
    set_cfg(4, 5, 1'b0, 1'b0);
    @(negedge clk_i);
    vec++; if (cfg_err_o !== 1'b0) begin err++; $display("FAIL min_cfg_err got %b exp 0", cfg_err_o); end
    next_cycle();
  endtask

  task automatic test_enable_drop();
    set_cfg(8, 8, 1'b0, 1'b0);
    enable_i = 1'b1;
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk_i);
      if (n == 20) prescale_i = 6'd5;
      next_cycle();
    end
    enable_i = 1'b0;
    @(negedge clk_i);
    vec++; if (bit_cnt_o !== 4'd4 || edge_cnt_o !== 6'd5)
      begin err++; $display("FAIL drop_pos got b%0d e%0d exp b4 e5", bit_cnt_o, edge_cnt_o); end
    vec++; if ({sample_stb_o, bit_tick_o} !== 2'b00)
      begin err++; $display("FAIL drop_strobe got %b exp 00", {sample_stb_o, bit_tick_o}); end
    next_cycle();
    @(negedge clk_i);
    vec++; if (bit_cnt_o !== 4'd0 || edge_cnt_o !== 6'd0)
      begin err++; $display("FAIL drop_clear got b%0d e%0d exp b0 e0", bit_cnt_o, edge_cnt_o); end
    prescale_i = 6'd8;
    next_cycle();
    enable_i = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk_i);
      vec++; if (bit_tick_o !== (n == 8)) begin err++; $display("FAIL reen_tick c%0d got %b exp %b", n, bit_tick_o, (n == 8)); end
      if (n == 1 || n == 9) begin
        vec++; if (bit_cnt_o !== 4'((n - 1) / 8))
          begin err++; $display("FAIL reen_bit c%0d got %0d exp %0d", n, bit_cnt_o, (n - 1) / 8); end
      end
      next_cycle();
    end
    enable_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    set_cfg(4, 5, 1'b0, 1'b0);
    enable_i = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_i);
      vec++; if (frame_done_o !== ((n % 28) == 0))
        begin err++; $display("FAIL b2b_done c%0d got %b exp %b", n, frame_done_o, ((n % 28) == 0)); end
      vec++; if (bit_cnt_o !== 4'(((n - 1) / 4) % 7))
        begin err++; $display("FAIL b2b_bit c%0d got %0d exp %0d", n, bit_cnt_o, ((n - 1) / 4) % 7); end
      next_cycle();
    end
    enable_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    set_cfg(4, 5, 1'b0, 1'b0);
    enable_i = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk_i);
      next_cycle();
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    vec++; if (bit_cnt_o !== 4'd6) begin err++; $display("FAIL rstmid_pos got %0d exp 6", bit_cnt_o); end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    vec++; if ({edge_cnt_o, bit_cnt_o, sample_stb_o, bit_tick_o, frame_done_o, cfg_err_o} !== 14'd0)
      begin err++; $display("FAIL rstmid_clear got e%0d b%0d s%b t%b d%b c%b exp all 0", edge_cnt_o, bit_cnt_o,
                            sample_stb_o, bit_tick_o, frame_done_o, cfg_err_o); end
    next_cycle();
    set_cfg(4, 5, 1'b0, 1'b0);
    enable_i = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk_i);
      vec++; if (bit_tick_o !== (n == 4)) begin err++; $display("FAIL rstmid_tick c%0d got %b exp %b", n, bit_tick_o, (n == 4)); end
      next_cycle();
    end
    enable_i = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_max_frame();
    test_sample_points();
    test_cfg_err();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
